// File: rtl/rv32_branch_predictor.sv
// -----------------------------------------------------------------------------
// rv32_branch_predictor
//
// Fetch-stage dynamic branch predictor. A direct-mapped branch target buffer
// (BTB) with a 2-bit saturating counter per entry. It is looked up with the
// fetch PC and gives a registered prediction one cycle later. The execute
// stage writes resolved outcomes back through the update port.
//
// Configuration macro: RV32_BRANCH_PREDICTOR_EN
//   defined   : BTB + counters as described above.
//   undefined : no BTB storage and the update port is ignored. The output
//               registers remain and predict static not-taken (pc_in + 4).
//
// Ports
//   clk                  clock, rising edge
//   reset_n              asynchronous active-low reset
//   stall_in             hold the lookup output registers (pc_in not consumed)
//   pc_in[31:0]          fetch PC to look up
//   predicted_taken_out  registered taken prediction
//   predicted_pc_out     registered next-PC prediction
//   update_valid_in      resolved branch/jump write this cycle
//   update_pc_in[31:0]   PC of the resolved branch
//   update_taken_in      resolved direction
//   update_target_in     resolved taken target (bit 0 already cleared)
// -----------------------------------------------------------------------------
module rv32_branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic [31:0] pc_in,
  output logic        predicted_taken_out,
  output logic [31:0] predicted_pc_out,
  input  logic        update_valid_in,
  input  logic [31:0] update_pc_in,
  input  logic        update_taken_in,
  input  logic [31:0] update_target_in
);

  logic        next_taken;
  logic [31:0] next_pc;

`ifdef RV32_BRANCH_PREDICTOR_EN
  localparam int NUM_ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_BITS    = 30 - INDEX_BITS;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  logic                  valid_q  [NUM_ENTRIES];
  logic [1:0]            ctr_q    [NUM_ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [NUM_ENTRIES];
  logic [31:0]           target_q [NUM_ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_hit;
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0]   up_tag;
  logic                  up_hit;

  assign lk_idx = pc_in[INDEX_BITS+1:2];
  assign lk_tag = pc_in[31:INDEX_BITS+2];
  assign up_idx = update_pc_in[INDEX_BITS+1:2];
  assign up_tag = update_pc_in[31:INDEX_BITS+2];

  // Both ports read the array as it stood before this edge: no bypass.
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    next_taken = 1'b0;
    next_pc    = pc_in + 32'd4;
    if (lk_hit && ctr_q[lk_idx][1]) begin
      next_taken = 1'b1;
      next_pc    = target_q[lk_idx];
    end
  end

  // Valid bits and counters are the only array state that must reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WEAK_NT;
      end
    end else if (update_valid_in) begin
      if (up_hit) begin
        if (update_taken_in) begin
          if (ctr_q[up_idx] != CTR_STRONG_T) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
        end else begin
          if (ctr_q[up_idx] != CTR_STRONG_NT) ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
        end
      end else if (update_taken_in) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_WEAK_T;
      end
    end
  end

  // NOTE: tag/target storage is deliberately not reset; it is ignored while
  // its valid bit is clear, and leaving it unreset lets it map to plain RAM.
  // A taken update rewrites the tag: on a hit it is unchanged, on a miss it
  // allocates.
  always_ff @(posedge clk) begin
    if (update_valid_in && update_taken_in) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= update_target_in;
    end
  end

  logic unused_bits;
  assign unused_bits = ^update_pc_in[1:0];
`else
  // Static not-taken: next PC is always the sequential PC.
  assign next_taken = 1'b0;
  assign next_pc    = pc_in + 32'd4;

  logic unused_bits;
  assign unused_bits = ^{update_valid_in, update_pc_in, update_taken_in, update_target_in};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      predicted_taken_out <= 1'b0;
      predicted_pc_out    <= 32'h0000_0000;
    end else if (!stall_in) begin
      predicted_taken_out <= next_taken;
      predicted_pc_out    <= next_pc;
    end
  end

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_rv32_branch_predictor
//
// Directed self-checking bench for rv32_branch_predictor (INDEX_BITS = 4).
// With RV32_BRANCH_PREDICTOR_EN defined it exercises allocation, hysteresis,
// saturation, aliasing, same-cycle update/lookup, stall and reset. Without
// the macro it checks the static not-taken behaviour.
// -----------------------------------------------------------------------------
module tb_rv32_branch_predictor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_in;
  logic [31:0] pc_in;
  logic        predicted_taken_out;
  logic [31:0] predicted_pc_out;
  logic        update_valid_in;
  logic [31:0] update_pc_in;
  logic        update_taken_in;
  logic [31:0] update_target_in;

  int checks = 0;
  int errors = 0;

  rv32_branch_predictor #(.INDEX_BITS(4)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .stall_in            (stall_in),
    .pc_in               (pc_in),
    .predicted_taken_out (predicted_taken_out),
    .predicted_pc_out    (predicted_pc_out),
    .update_valid_in     (update_valid_in),
    .update_pc_in        (update_pc_in),
    .update_taken_in     (update_taken_in),
    .update_target_in    (update_target_in)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_update(input logic v, input logic [31:0] pc,
                            input logic t, input logic [31:0] tgt);
    update_valid_in  = v;
    update_pc_in     = pc;
    update_taken_in  = t;
    update_target_in = tgt;
  endtask

  // Present pc_in (and optionally an update) for one edge, then compare.
  task automatic lookup(input string name, input logic [31:0] pc,
                        input logic exp_t, input logic [31:0] exp_pc);
    pc_in = pc;
    step();
    set_update(1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (predicted_taken_out !== exp_t || predicted_pc_out !== exp_pc) begin
      errors++;
      $display("FAIL %s: got taken=%b pc=%08h, expected taken=%b pc=%08h",
               name, predicted_taken_out, predicted_pc_out, exp_t, exp_pc);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    stall_in = 1'b0;
    pc_in    = 32'h0000_0100;
    set_update(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    step();
    checks++;
    if (predicted_taken_out !== 1'b0 || predicted_pc_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got taken=%b pc=%08h, expected taken=0 pc=00000000",
               predicted_taken_out, predicted_pc_out);
    end
    reset_n = 1'b1;
    #2;
  endtask

  task automatic test_cold_miss();
    lookup("cold_miss", 32'h0000_0100, 1'b0, 32'h0000_0104);
    lookup("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
  endtask

  task automatic test_stall(input logic exp_t, input logic [31:0] exp_pc);
    logic [31:0] stall_pcs [3];
    stall_pcs[0] = 32'h0000_0500;
    stall_pcs[1] = 32'h0000_0600;
    stall_pcs[2] = 32'h0000_0700;
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // An update issued while stalled must still be written.
      if (i == 0) set_update(1'b1, 32'h0000_0504, 1'b1, 32'h0000_0010);
      lookup($sformatf("stall_hold_%0d", i), stall_pcs[i], exp_t, exp_pc);
    end
    stall_in = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    pc_in = 32'h0000_0900;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (predicted_taken_out !== 1'b0 || predicted_pc_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: got taken=%b pc=%08h, expected taken=0 pc=00000000",
               predicted_taken_out, predicted_pc_out);
    end
    step();
    reset_n = 1'b1;
    #2;
  endtask

`ifdef RV32_BRANCH_PREDICTOR_EN
  typedef struct {
    logic        upd;
    logic        taken;
    logic [31:0] target;
    logic        exp_t;
    logic [31:0] exp_pc;
  } hyst_vec_t;

  task automatic test_allocation();
    // Update alone; the unrelated lookup of 0x0 proves the update is not
    // seen as a hit elsewhere.
    set_update(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0080);
    lookup("alloc_other_pc", 32'h0000_0000, 1'b0, 32'h0000_0004);
    lookup("alloc_hit", 32'h0000_0100, 1'b1, 32'h0000_0080);
  endtask

  // Each row: optional update of 0x100 in the same cycle as a lookup of 0x100.
  // The lookup observes the counter/target as they were before that edge.
  task automatic test_hysteresis();
    hyst_vec_t v [18];
    v[0]  = '{1'b1, 1'b0, 32'h80, 1'b1, 32'h80};   // 10 -> 01
    v[1]  = '{1'b1, 1'b0, 32'h80, 1'b0, 32'h104};  // 01 -> 00
    v[2]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h104};  // 00
    v[3]  = '{1'b1, 1'b1, 32'h80, 1'b0, 32'h104};  // 00 -> 01
    v[4]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h104};  // 01
    v[5]  = '{1'b1, 1'b1, 32'h88, 1'b0, 32'h104};  // 01 -> 10, target 0x88
    v[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h88};   // 10
    v[7]  = '{1'b1, 1'b1, 32'h88, 1'b1, 32'h88};   // 10 -> 11
    v[8]  = '{1'b1, 1'b1, 32'h88, 1'b1, 32'h88};   // 11 saturates
    v[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h88};   // 11 -> 10
    v[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h88};   // 10
    v[11] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h88};   // 10 -> 01
    v[12] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h104};  // 01 -> 00
    v[13] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h104};  // 00 saturates
    v[14] = '{1'b1, 1'b1, 32'h88, 1'b0, 32'h104};  // 00 -> 01
    v[15] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h104};  // 01
    v[16] = '{1'b1, 1'b1, 32'h88, 1'b0, 32'h104};  // 01 -> 10
    v[17] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h88};   // 10
    for (int i = 0; i < 18; i++) begin
      set_update(v[i].upd, 32'h0000_0100, v[i].taken, v[i].target);
      lookup($sformatf("hyst_%0d", i), 32'h0000_0100, v[i].exp_t, v[i].exp_pc);
    end
  endtask

  // 0x100 and 0x140 share index 0 with tags 4 and 5.
  task automatic test_aliasing();
    lookup("alias_miss", 32'h0000_0140, 1'b0, 32'h0000_0144);
    set_update(1'b1, 32'h0000_0140, 1'b0, 32'h0000_0300);
    lookup("alias_nt_update", 32'h0000_0000, 1'b0, 32'h0000_0004);
    lookup("alias_keep_0x100", 32'h0000_0100, 1'b1, 32'h0000_0088);
    set_update(1'b1, 32'h0000_0140, 1'b1, 32'h0000_0300);
    lookup("alias_t_update", 32'h0000_0000, 1'b0, 32'h0000_0004);
    lookup("alias_evicted_0x100", 32'h0000_0100, 1'b0, 32'h0000_0104);
    lookup("alias_new_0x140", 32'h0000_0140, 1'b1, 32'h0000_0300);
  endtask

  task automatic test_back_to_back();
    set_update(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0400);
    lookup("same_cycle_miss", 32'h0000_0200, 1'b0, 32'h0000_0204);
    lookup("next_cycle_hit", 32'h0000_0200, 1'b1, 32'h0000_0400);
  endtask

  task automatic test_after_stall_and_reset();
    lookup("stall_update_written", 32'h0000_0504, 1'b1, 32'h0000_0010);
    test_reset_mid_run();
    lookup("post_reset_miss_504", 32'h0000_0504, 1'b0, 32'h0000_0508);
    lookup("post_reset_miss_200", 32'h0000_0200, 1'b0, 32'h0000_0204);
  endtask
`else
  task automatic test_static();
    for (int i = 0; i < 3; i++) begin
      set_update(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0080);
      lookup($sformatf("static_upd_%0d", i), 32'h0000_0100, 1'b0, 32'h0000_0104);
    end
    lookup("static_after_upd", 32'h0000_0100, 1'b0, 32'h0000_0104);
    lookup("static_pc_200", 32'h0000_0200, 1'b0, 32'h0000_0204);
  endtask

  task automatic test_after_stall_and_reset();
    lookup("stall_release", 32'h0000_0504, 1'b0, 32'h0000_0508);
    test_reset_mid_run();
    lookup("post_reset_static", 32'h0000_0100, 1'b0, 32'h0000_0104);
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
`ifdef RV32_BRANCH_PREDICTOR_EN
    test_allocation();
    test_hysteresis();
    test_aliasing();
    test_back_to_back();
    test_stall(1'b1, 32'h0000_0400);
`else
    test_static();
    test_stall(1'b0, 32'h0000_0204);
`endif
    test_after_stall_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/rv32_branch_predictor.md
# rv32_branch_predictor

Dynamic branch predictor for the fetch stage: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. It is looked up with the fetch PC and produces, one cycle later, `predicted_taken_out` and `predicted_pc_out`. The taken flag travels down the pipeline as the `predicted_taken_in` of the execute-stage branch PC mux and branch unit. The execute stage writes back the resolved outcome and target through the update port.

## Interface
- `INDEX_BITS`, default 4: BTB index width; 2^INDEX_BITS entries.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `stall_in` input 1: when high, the lookup output registers hold their values.
- `pc_in` input 32: fetch PC to look up.
- `predicted_taken_out` output 1: registered prediction for the PC presented on the previous non-stalled cycle.
- `predicted_pc_out` output 32: registered next-PC prediction.
- `update_valid_in` input 1: a resolved branch or jump is being written this cycle.
- `update_pc_in` input 32: PC of the resolved branch.
- `update_taken_in` input 1: resolved direction (branch unit `taken_out`).
- `update_target_in` input 32: resolved taken target, bit 0 already cleared.

## Operation
- Index: `pc[INDEX_BITS+1:2]`. Tag: `pc[31:INDEX_BITS+2]`. PC bits [1:0] are ignored.
- Each entry holds:
  - valid bit
  - tag
  - 32-bit target
  - 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
- Lookup:
  - hit = `valid && tag == pc_in tag`.
  - taken = `hit && counter[1]`.
  - `predicted_pc` = target if taken, else `pc_in + 4` (modulo 2^32; 0xFFFFFFFC wraps to 0).
- Update, when `update_valid_in` is high. Hit is evaluated against `update_pc_in`.
  - Hit: counter saturating-increments if taken, saturating-decrements if not taken. Target is overwritten with `update_target_in` when taken. Valid and tag are unchanged.
  - Miss and taken: allocate the entry, replacing any occupant. Set valid=1, tag, target; counter=10.
  - Miss and not taken: no state change.
- Lookup and update are independent. With `stall_in` high, the update still writes.
- No write-to-read bypass. A lookup in cycle N reads the array state as it was before the cycle-N update edge.

## Timing
- Lookup latency is 1 cycle: `pc_in` sampled at edge N appears on the outputs after edge N.
- `stall_in` high at an edge: output registers keep their previous values, and `pc_in` is not consumed.
- Update takes effect at the edge where `update_valid_in` is high. It is visible to lookups sampled at the next edge or later.
- Reset (`reset_n` low, asynchronous, effective immediately, including mid-operation):
  - all valid bits = 0
  - all counters = 01
  - `predicted_taken_out` = 0
  - `predicted_pc_out` = 0x00000000
- Tags and targets need no reset; they are ignored while invalid.
- The first edge after `reset_n` deasserts performs a normal lookup and update.
- Boundaries:
  - Counter at 11 and taken: stays at 11.
  - Counter at 00 and not taken: stays at 00.
  - Aliasing PCs (same index, different tag) evict each other only on a taken miss.

## Configuration
- `RV32_BRANCH_PREDICTOR_EN` defined: behaviour as above.
- Undefined:
  - No BTB storage is instantiated.
  - The update port is ignored.
  - Output registers still exist and honour `stall_in` and reset.
  - `predicted_taken_out` is always 0 and `predicted_pc_out` = registered `pc_in + 4` (static not-taken).

## Test plan
- Cold miss after reset: lookup 0x00000100 → next cycle taken=0, pc=0x00000104.
- Allocation: update pc=0x100, taken, target=0x80; lookup 0x100 on the following cycle → taken=1, pc=0x00000080.
- Hysteresis:
  - Starting from the allocated entry (counter 10), two not-taken updates → counter 00 and lookup not taken.
  - One taken update → counter 01, still not taken.
  - A second taken update → taken.
- Aliasing with INDEX_BITS=4:
  - With 0x100 allocated, lookup 0x140 → miss, taken=0, pc=0x144.
  - Not-taken update of 0x140 → 0x100 still predicted taken.
  - Taken update of 0x140 → 0x100 misses.
- Same-cycle update and lookup of 0x200 (first taken update) → output shows the miss; a repeat lookup next cycle → taken.
- Control and configuration:
  - `stall_in` high for 3 cycles while `pc_in` changes → outputs constant.
  - `reset_n` pulsed low mid-run → outputs 0 immediately and all entries miss afterwards.
  - Macro undefined: any update sequence leaves taken=0.
